// File: rtl/data_memory_mmio.sv
// Dual-port data memory: LANES-wide masked vector port A, scalar read-only port B,
// plus an IO window with synchronised switches and a GPIO block with direction control.
module data_memory_mmio #(
  parameter int WORD_W  = 16,
  parameter int LANES   = 9,
  parameter int ADDR_W  = 20,
  parameter int DEPTH   = 4096,
  parameter int IO_BASE = 5000,
  parameter int SW_W    = 4,
  parameter int GPIO_W  = 36
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    memWrite,
  input  logic [LANES-1:0]        laneMask,
  input  logic [ADDR_W-1:0]       address1,
  input  logic [LANES*WORD_W-1:0] data1,
  input  logic [ADDR_W-1:0]       address2,
  input  logic [SW_W-1:0]         switches,
  input  logic [GPIO_W-1:0]       gpio_in,
  output logic [LANES*WORD_W-1:0] qa,
  output logic [WORD_W-1:0]       qb,
  output logic [GPIO_W-1:0]       gpio_out,
  output logic [GPIO_W-1:0]       gpio_oe,
  output logic                    accErr
);
  localparam int VW = LANES * WORD_W;
  localparam int AW = $clog2(DEPTH);
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] IO_SW   = (ADDR_W+1)'(IO_BASE);
  localparam logic [ADDR_W:0] IO_OUT  = (ADDR_W+1)'(IO_BASE + 1);
  localparam logic [ADDR_W:0] IO_DIR  = (ADDR_W+1)'(IO_BASE + 2);
  localparam logic [ADDR_W:0] IO_IN   = (ADDR_W+1)'(IO_BASE + 3);

  logic [WORD_W-1:0] mem [DEPTH];

  logic [SW_W-1:0]   sw_sync_p0, sw_sync_p1;
  logic [GPIO_W-1:0] gpio_sync_p0, gpio_sync_p1;

  logic [ADDR_W:0]   a1x, a2x;
  logic [ADDR_W:0]   lane_addr [LANES];
  logic [LANES-1:0]  lane_ok, lane_wr;
  logic              ram_sel, sw_sel, out_sel, dir_sel, in_sel, unmapped;
  logic [VW-1:0]     rd_vec;
  logic [WORD_W-1:0] qb_nxt;
  logic [GPIO_W-1:0] gpio_rd, out_nxt, dir_nxt;

  // Address decode; the extra top bit keeps address1+i from wrapping.
  always_comb begin
    a1x      = {1'b0, address1};
    a2x      = {1'b0, address2};
    ram_sel  = a1x < DEPTH_X;
    sw_sel   = a1x == IO_SW;
    out_sel  = a1x == IO_OUT;
    dir_sel  = a1x == IO_DIR;
    in_sel   = a1x == IO_IN;
    unmapped = !(ram_sel || sw_sel || out_sel || dir_sel || in_sel);
    for (int i = 0; i < LANES; i++) begin
      lane_addr[i] = a1x + (ADDR_W+1)'(i);
      lane_ok[i]   = ram_sel && (lane_addr[i] < DEPTH_X);
      lane_wr[i]   = memWrite && laneMask[i] && lane_ok[i];
    end
  end

  // Output-driven GPIO bits loop back their own register value.
  assign gpio_rd = (gpio_oe & gpio_out) | (~gpio_oe & gpio_sync_p1);

  always_comb begin
    rd_vec = '0;
    if (ram_sel) begin
      for (int i = 0; i < LANES; i++)
        if (lane_ok[i]) rd_vec[i*WORD_W +: WORD_W] = mem[lane_addr[i][AW-1:0]];
    end else if (sw_sel) begin
      rd_vec = VW'(sw_sync_p1);
    end else if (out_sel) begin
      rd_vec = VW'(gpio_out);
    end else if (dir_sel) begin
      rd_vec = VW'(gpio_oe);
    end else if (in_sel) begin
      rd_vec = VW'(gpio_rd);
    end
  end

  // Port B is write-first against a same-cycle port-A lane write.
  always_comb begin
    qb_nxt = '0;
    if (a2x < DEPTH_X) qb_nxt = mem[address2[AW-1:0]];
    for (int i = 0; i < LANES; i++)
      if (lane_wr[i] && (lane_addr[i] == a2x)) qb_nxt = data1[i*WORD_W +: WORD_W];
  end

  // GPIO bit k belongs to lane k/WORD_W of the vector access.
  always_comb begin
    out_nxt = gpio_out;
    dir_nxt = gpio_oe;
    for (int k = 0; k < GPIO_W; k++) begin
      if (memWrite && out_sel && laneMask[k/WORD_W]) out_nxt[k] = data1[k];
      if (memWrite && dir_sel && laneMask[k/WORD_W]) dir_nxt[k] = data1[k];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_sync_p0   <= '0;
      sw_sync_p1   <= '0;
      gpio_sync_p0 <= '0;
      gpio_sync_p1 <= '0;
      qa           <= '0;
      qb           <= '0;
      gpio_out     <= '0;
      gpio_oe      <= '0;
      accErr       <= 1'b0;
    end else begin
      sw_sync_p0   <= switches;
      sw_sync_p1   <= sw_sync_p0;
      gpio_sync_p0 <= gpio_in;
      gpio_sync_p1 <= gpio_sync_p0;
      qa           <= rd_vec;
      qb           <= qb_nxt;
      gpio_out     <= out_nxt;
      gpio_oe      <= dir_nxt;
      accErr       <= unmapped;
    end
  end

  // RAM has no reset; a write landing on the same edge as reset is dropped.
  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++)
      if (lane_wr[i] && !rst) mem[lane_addr[i][AW-1:0]] <= data1[i*WORD_W +: WORD_W];
  end

endmodule
